sreg_status_sched: RTL and testbench

Time-multiplexes up to 16 status sources onto one 32-bit software-register word (the `user_data_in` of an `opb_register_simulink2ppc` instance) with round-robin arbitration. This lets many fabric counters (loopback rx/tx counts, error counters) share a single OPB address slot. Each published word carries the source index and a sequence nibble, so PPC software can demultiplex it. Each value is held for a guaranteed dwell time, so a 32-bit OPB read never sees a torn or stale-mid-update value.

---
 rtl/sreg_sched_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/sreg_status_sched.sv | 108 ++++++++++
 tb/tb_sreg_status_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sreg_sched_pkg.sv
// Shared constants, word layout and FSM states for the status scheduler.
// Also carries the field masks PPC software uses to split a published word.
package sreg_sched_pkg;

    localparam int IDX_W     = 4;
    localparam int SEQ_W     = 4;
    localparam int PAYLOAD_W = 24;

    localparam int IDX_LSB = 28;
    localparam int SEQ_LSB = 24;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic [31:0] SW_IDX_MASK  = 32'hF000_0000;
    localparam logic [31:0] SW_SEQ_MASK  = 32'h0F00_0000;
    localparam logic [31:0] SW_DATA_MASK = 32'h00FF_FFFF;

    function automatic logic [31:0] pack_word(
        input logic [IDX_W-1:0]     idx,
        input logic [SEQ_W-1:0]     seq,
        input logic [PAYLOAD_W-1:0] data
    );
        return {idx, seq, data};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: rotate requests by ptr, pick lowest, rotate back.
// Purely combinational; the pointer register lives in the parent.
module rr_arbiter
    import sreg_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [N-1:0]     rot;
    logic [N-1:0]     hot;
    logic [IDX_W-1:0] pos;

    // rotate so the pointer's source sits at bit 0
    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req_i[(int'(ptr_i) + i) % N];
        end
    end

    // fixed priority on the rotated vector: lowest bit wins
    always_comb begin
        hot = '0;
        pos = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                hot    = '0;
                hot[i] = 1'b1;
                pos    = IDX_W'(i);
            end
        end
    end

    // rotate the one-hot back and form the absolute index
    always_comb begin
        gnt_o = '0;
        for (int i = 0; i < N; i++) begin
            gnt_o[(int'(ptr_i) + i) % N] = hot[i];
        end
        idx_o = IDX_W'((int'(pos) + int'(ptr_i)) % N);
        any_o = |req_i;
    end

endmodule

// File: rtl/sreg_status_sched.sv
// Multiplexes N_SRC status sources onto one 32-bit software register word.
// Each published word is held for HOLD_CYCLES so reads never see it change.
module sreg_status_sched
    import sreg_sched_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int DW          = 24,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic                OPB_Clk,
    input  logic                OPB_Rst,
    input  logic [N_SRC-1:0]    src_req,
    input  logic [N_SRC*DW-1:0] src_data,
    output logic [N_SRC-1:0]    src_ack,
    input  logic                freeze,
    output logic [31:0]         sreg_word,
    output logic                pub,
    output logic                busy
);

    localparam int CW = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [SEQ_W-1:0] seq_q;
    logic [SEQ_W-1:0] seq_d;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [31:0]      word_q;
    logic [31:0]      word_d;
    logic [N_SRC-1:0] ack_q;
    logic             pub_q;
    logic             busy_q;

    logic [N_SRC-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_any;
    logic [DW-1:0]    sel_data;

    rr_arbiter #(
        .N (N_SRC)
    ) u_arb (
        .req_i (src_req),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    // select the granted source's payload and build the next word
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (gnt[i]) begin
                sel_data = src_data[i*DW +: DW];
            end
        end
        seq_d  = seq_q + 1'b1;
        ptr_d  = IDX_W'((int'(gnt_idx) + 1) % N_SRC);
        word_d = pack_word(gnt_idx, seq_d, sel_data);
    end

    // grant/hold FSM with all outputs registered
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            seq_q   <= '0;
            ptr_q   <= '0;
            word_q  <= '0;
            ack_q   <= '0;
            pub_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= '0;
            pub_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!freeze && gnt_any) begin
                        word_q  <= word_d;
                        seq_q   <= seq_d;
                        ptr_q   <= ptr_d;
                        ack_q   <= gnt;
                        pub_q   <= 1'b1;
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    assign sreg_word = word_q;
    assign src_ack   = ack_q;
    assign pub       = pub_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sreg_status_sched.sv
// Self-checking bench for sreg_status_sched (N_SRC=4, HOLD_CYCLES=8).
// Directed table, corner sequences and random traffic against a time-based model.
module tb_sreg_status_sched;

    localparam int N = 4;
    localparam int H = 8;

    logic          OPB_Clk;
    logic          OPB_Rst;
    logic [N-1:0]  src_req;
    logic [95:0]   src_data;
    logic [N-1:0]  src_ack;
    logic          freeze;
    logic [31:0]   sreg_word;
    logic          pub;
    logic          busy;
    logic [23:0]   dat [N];

    int n_cmp = 0;
    int n_bad = 0;

    assign src_data = {dat[3], dat[2], dat[1], dat[0]};

    sreg_status_sched #(
        .N_SRC       (N),
        .DW          (24),
        .HOLD_CYCLES (H)
    ) dut (
        .OPB_Clk   (OPB_Clk),
        .OPB_Rst   (OPB_Rst),
        .src_req   (src_req),
        .src_data  (src_data),
        .src_ack   (src_ack),
        .freeze    (freeze),
        .sreg_word (sreg_word),
        .pub       (pub),
        .busy      (busy)
    );

    initial begin
        OPB_Clk = 1'b0;
        forever #5 OPB_Clk = ~OPB_Clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // reference model: a capture is allowed when more than H edges
    // have passed since the last one
    int          cyc = 0;
    int          last_cap = 0;
    bit          have_cap = 0;
    int          m_ptr = 0;
    logic [3:0]  m_seq = '0;
    logic [31:0] m_word = '0;
    logic        m_pub = 1'b0;
    logic [3:0]  m_ack = '0;
    logic        m_busy = 1'b0;

    task automatic model_edge();
        bit found;
        int s;
        cyc++;
        m_pub = 1'b0;
        m_ack = '0;
        if (OPB_Rst) begin
            have_cap = 0;
            m_ptr    = 0;
            m_seq    = '0;
            m_word   = '0;
            m_busy   = 1'b0;
        end else begin
            if ((!have_cap || (cyc - last_cap) > H) && !freeze && src_req != 0) begin
                found = 0;
                for (int o = 0; o < N; o++) begin
                    s = (m_ptr + o) % N;
                    if (!found && src_req[s]) begin
                        found    = 1;
                        m_seq    = m_seq + 4'd1;
                        m_word   = {4'(s), m_seq, dat[s]};
                        m_pub    = 1'b1;
                        m_ack[s] = 1'b1;
                        m_ptr    = (s + 1) % N;
                        last_cap = cyc;
                        have_cap = 1;
                    end
                end
            end
            m_busy = have_cap && ((cyc - last_cap) < H);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge OPB_Clk);
        model_edge();
        #1;
        chk("model_word", sreg_word, m_word);
        chk("model_pub", 32'(pub), 32'(m_pub));
        chk("model_ack", 32'(src_ack), 32'(m_ack));
        chk("model_busy", 32'(busy), 32'(m_busy));
    endtask

    task automatic wait_pub(input int budget, output bit ok);
        int k;
        ok = 0;
        k = 0;
        while (!ok && k < budget) begin
            tick();
            k++;
            if (pub) ok = 1;
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        logic        frz;
        int          ncyc;
        logic [31:0] w;
        logic        p;
        logic [3:0]  a;
        logic        b;
    } vec_t;

    vec_t tbl [8];

    initial begin
        bit ok;
        bit seen3;
        int npub;
        int prev;

        tbl[0] = '{4'h0, 1'b0, 100, 32'h0000_0000, 1'b0, 4'h0, 1'b0};
        tbl[1] = '{4'hF, 1'b0, 1,   32'h0100_000A, 1'b1, 4'h1, 1'b1};
        tbl[2] = '{4'hF, 1'b0, 1,   32'h0100_000A, 1'b0, 4'h0, 1'b1};
        tbl[3] = '{4'hF, 1'b0, 7,   32'h0100_000A, 1'b0, 4'h0, 1'b0};
        tbl[4] = '{4'hF, 1'b0, 1,   32'h1200_000B, 1'b1, 4'h2, 1'b1};
        tbl[5] = '{4'hF, 1'b0, 9,   32'h2300_000C, 1'b1, 4'h4, 1'b1};
        tbl[6] = '{4'hF, 1'b0, 9,   32'h3400_000D, 1'b1, 4'h8, 1'b1};
        tbl[7] = '{4'hF, 1'b0, 9,   32'h0500_000A, 1'b1, 4'h1, 1'b1};

        for (int i = 0; i < N; i++) dat[i] = 24'h00000A + 24'(i);
        src_req = '0;
        freeze  = 1'b0;
        OPB_Rst = 1'b1;
        tick();
        tick();
        chk("rst_word", sreg_word, 32'h0);
        chk("rst_pub", 32'(pub), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ack", 32'(src_ack), 32'h0);
        OPB_Rst = 1'b0;

        // all-request round robin from reset
        for (int r = 0; r < 8; r++) begin
            src_req = tbl[r].req;
            freeze  = tbl[r].frz;
            for (int k = 0; k < tbl[r].ncyc; k++) tick();
            chk($sformatf("tbl%0d_word", r), sreg_word, tbl[r].w);
            chk($sformatf("tbl%0d_pub", r), 32'(pub), 32'(tbl[r].p));
            chk($sformatf("tbl%0d_ack", r), 32'(src_ack), 32'(tbl[r].a));
            chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].b));
        end

        // freeze two cycles into hold: hold finishes, nothing published
        tick();
        tick();
        freeze = 1'b1;
        npub = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (pub) npub++;
        end
        chk("frz_no_pub", 32'(npub), 32'h0);
        chk("frz_idle", 32'(busy), 32'h0);
        chk("frz_word", sreg_word, 32'h0500_000A);
        freeze = 1'b0;
        tick();
        chk("rel_pub", 32'(pub), 32'h1);
        chk("rel_word", sreg_word, 32'h1600_000B);

        // reset three cycles into the hold of source 1
        tick();
        tick();
        tick();
        OPB_Rst = 1'b1;
        tick();
        chk("mrst_word", sreg_word, 32'h0);
        chk("mrst_busy", 32'(busy), 32'h0);
        chk("mrst_ack", 32'(src_ack), 32'h0);
        OPB_Rst = 1'b0;
        src_req = 4'hF;
        tick();
        chk("mrst_next_word", sreg_word, 32'h0100_000A);
        chk("mrst_next_ack", 32'(src_ack), 32'h1);

        // source 3 withdraws during source 2's hold and is skipped
        OPB_Rst = 1'b1;
        tick();
        OPB_Rst = 1'b0;
        src_req = 4'b1100;
        tick();
        chk("drop_first", sreg_word, 32'h2100_000C);
        tick();
        tick();
        src_req = 4'b0001;
        seen3 = 0;
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            tick();
            if (src_ack[3]) seen3 = 1;
            if (pub) ok = 1;
        end
        chk("drop_pub_seen", 32'(ok), 32'h1);
        chk("drop_word", sreg_word, 32'h0200_000A);
        chk("drop_no_ack3", 32'(seen3), 32'h0);

        // single source: one capture every H+1 cycles, seq wraps
        OPB_Rst = 1'b1;
        src_req = '0;
        tick();
        OPB_Rst = 1'b0;
        src_req = 4'b0100;
        prev = 0;
        for (int n = 1; n <= 16; n++) begin
            wait_pub(20, ok);
            chk($sformatf("solo%0d_pub", n), 32'(ok), 32'h1);
            chk($sformatf("solo%0d_word", n), sreg_word, {4'd2, 4'(n), 24'h00000C});
            chk($sformatf("solo%0d_ack", n), 32'(src_ack), 32'h4);
            if (n > 1) chk($sformatf("solo%0d_gap", n), 32'(cyc - prev), 32'(H + 1));
            prev = cyc;
        end

        // random traffic; payload only changes while its request is low
        src_req = 4'(($urandom));
        freeze  = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!src_req[i]) dat[i] = 24'($urandom);
                if ($urandom_range(0, 7) == 0) src_req[i] = ~src_req[i];
            end
            if ($urandom_range(0, 15) == 0) freeze = ~freeze;
            OPB_Rst = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
